// File: rtl/element_reader_pkg.sv
// Shared definitions for the element RAM word format and the read-back FSM.
// The writer side uses the same field positions.
package element_reader_pkg;

  localparam int NODE_A_MSB   = 31;
  localparam int NODE_A_LSB   = 27;
  localparam int NODE_B_MSB   = 26;
  localparam int NODE_B_LSB   = 22;
  localparam int TYPE_MSB     = 21;
  localparam int TYPE_LSB     = 20;
  localparam int EXP_SIGN_BIT = 19;
  localparam int EXP_MAG_MSB  = 18;
  localparam int EXP_MAG_LSB  = 10;
  localparam int VALUE_MSB    = 9;
  localparam int VALUE_LSB    = 0;

  typedef enum logic [1:0] {
    TYPE_VSRC    = 2'd0,
    TYPE_ISRC    = 2'd1,
    TYPE_RES     = 2'd2,
    TYPE_INVALID = 2'd3
  } elem_type_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

endpackage

// File: rtl/element_unpack.sv
// Purely combinational slicer from a 32-bit element word to its typed fields.
// Also reused by the HEX browse display.
module element_unpack
  import element_reader_pkg::*;
(
  input  logic [31:0] word,
  output logic [4:0]  node_a,
  output logic [4:0]  node_b,
  output logic [1:0]  etype,
  output logic        exp_neg,
  output logic [8:0]  exp_mag,
  output logic [9:0]  value
);

  assign node_a  = word[NODE_A_MSB:NODE_A_LSB];
  assign node_b  = word[NODE_B_MSB:NODE_B_LSB];
  assign etype   = word[TYPE_MSB:TYPE_LSB];
  assign exp_neg = word[EXP_SIGN_BIT];
  assign exp_mag = word[EXP_MAG_MSB:EXP_MAG_LSB];
  assign value   = word[VALUE_MSB:VALUE_LSB];

endmodule

// File: rtl/element_reader.sv
// Walks entries 0..n-1 of the element RAM and presents each unpacked element
// on a valid/ready stream; pulses done once the last element is accepted.
module element_reader
  import element_reader_pkg::*;
#(
  parameter int RAM_LATENCY  = 1,
  parameter int MAX_ELEMENTS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  element_count,
  output logic [4:0]  element_addr,
  input  logic [31:0] element_q,
  output logic        elem_valid,
  input  logic        elem_ready,
  output logic [4:0]  elem_index,
  output logic [1:0]  elem_type,
  output logic [9:0]  elem_value,
  output logic        elem_exp_neg,
  output logic [8:0]  elem_exp_mag,
  output logic [4:0]  node_a,
  output logic [4:0]  node_b,
  output logic        elem_invalid,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] MAX_N = 6'(MAX_ELEMENTS);
  localparam logic [1:0] LAT   = 2'(RAM_LATENCY);

  state_e     state_r;
  logic [4:0] idx_r;
  logic [5:0] n_r;
  logic [1:0] wait_cnt_r;

  logic [4:0] node_a_s;
  logic [4:0] node_b_s;
  logic [1:0] etype_s;
  logic       exp_neg_s;
  logic [8:0] exp_mag_s;
  logic [9:0] value_s;
  logic [5:0] count_clamped_s;
  logic       last_s;

  element_unpack u_unpack (
    .word    (element_q),
    .node_a  (node_a_s),
    .node_b  (node_b_s),
    .etype   (etype_s),
    .exp_neg (exp_neg_s),
    .exp_mag (exp_mag_s),
    .value   (value_s)
  );

  assign count_clamped_s = (element_count > MAX_N) ? MAX_N : element_count;
  assign last_s          = ({1'b0, idx_r} == (n_r - 6'd1));

  // Read-back FSM; every output is registered here so the stream fields only change on capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      idx_r        <= 5'd0;
      n_r          <= 6'd0;
      wait_cnt_r   <= 2'd0;
      element_addr <= 5'd0;
      elem_valid   <= 1'b0;
      elem_index   <= 5'd0;
      elem_type    <= 2'd0;
      elem_value   <= 10'd0;
      elem_exp_neg <= 1'b0;
      elem_exp_mag <= 9'd0;
      node_a       <= 5'd0;
      node_b       <= 5'd0;
      elem_invalid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            n_r     <= count_clamped_s;
            idx_r   <= 5'd0;
            busy    <= 1'b1;
            state_r <= (count_clamped_s == 6'd0) ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FETCH: begin
          element_addr <= idx_r;
          wait_cnt_r   <= LAT;
          state_r      <= ST_WAIT;
        end
        // The counter reaches zero on the edge where element_q reflects the new address.
        ST_WAIT: begin
          if (wait_cnt_r == 2'd0) begin
            node_a       <= node_a_s;
            node_b       <= node_b_s;
            elem_type    <= etype_s;
            elem_exp_neg <= exp_neg_s;
            elem_exp_mag <= exp_mag_s;
            elem_value   <= value_s;
            elem_index   <= idx_r;
            elem_invalid <= (etype_s == TYPE_INVALID);
            elem_valid   <= 1'b1;
            state_r      <= ST_PRESENT;
          end else begin
            wait_cnt_r <= wait_cnt_r - 2'd1;
          end
        end
        ST_PRESENT: begin
          if (elem_ready) begin
            elem_valid   <= 1'b0;
            elem_invalid <= 1'b0;
            if (last_s) begin
              state_r <= ST_FINISH;
            end else begin
              idx_r   <= idx_r + 5'd1;
              state_r <= ST_FETCH;
            end
          end
        end
        ST_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_element_reader.sv
// Self-checking bench for element_reader: one instance per RAM latency (1 and 2),
// each driven through the same scenarios against a field-level reference model.
module tb_element_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        elem_ready;
  logic [5:0]  element_count;
  logic        start [0:1];
  logic [4:0]  ea    [0:1];
  logic [31:0] eq    [0:1];
  logic        ev    [0:1];
  logic [4:0]  ei    [0:1];
  logic [1:0]  et    [0:1];
  logic [9:0]  eval  [0:1];
  logic        eneg  [0:1];
  logic [8:0]  emag  [0:1];
  logic [4:0]  na    [0:1];
  logic [4:0]  nb    [0:1];
  logic        einv  [0:1];
  logic        busy  [0:1];
  logic        done  [0:1];

  logic [31:0] mem [0:31];
  logic [31:0] pipe2;

  int checks = 0;
  int errors = 0;

  // Behavioural RAMs: one with a single read register, one with two.
  always @(posedge clk) begin
    eq[0] <= mem[ea[0]];
    pipe2 <= mem[ea[1]];
    eq[1] <= pipe2;
  end

  element_reader #(.RAM_LATENCY(1), .MAX_ELEMENTS(32)) u_l1 (
    .clk(clk), .reset(reset), .start(start[0]), .element_count(element_count),
    .element_addr(ea[0]), .element_q(eq[0]), .elem_valid(ev[0]), .elem_ready(elem_ready),
    .elem_index(ei[0]), .elem_type(et[0]), .elem_value(eval[0]), .elem_exp_neg(eneg[0]),
    .elem_exp_mag(emag[0]), .node_a(na[0]), .node_b(nb[0]), .elem_invalid(einv[0]),
    .busy(busy[0]), .done(done[0])
  );

  element_reader #(.RAM_LATENCY(2), .MAX_ELEMENTS(32)) u_l2 (
    .clk(clk), .reset(reset), .start(start[1]), .element_count(element_count),
    .element_addr(ea[1]), .element_q(eq[1]), .elem_valid(ev[1]), .elem_ready(elem_ready),
    .elem_index(ei[1]), .elem_type(et[1]), .elem_value(eval[1]), .elem_exp_neg(eneg[1]),
    .elem_exp_mag(emag[1]), .node_a(na[1]), .node_b(nb[1]), .elem_invalid(einv[1]),
    .busy(busy[1]), .done(done[1])
  );

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] t;
    logic       neg;
    logic [8:0] mag;
    logic [9:0] val;
  } fields_t;

  // Reference decode using plain arithmetic on the documented word layout.
  function automatic fields_t model(input logic [31:0] w);
    fields_t     m;
    int unsigned x;
    int unsigned e;
    x     = w;
    e     = (x / 1024) % 1024;
    m.a   = 5'(x / 134217728);
    m.b   = 5'((x / 4194304) % 32);
    m.t   = 2'((x / 1048576) % 4);
    m.neg = 1'(e / 512);
    m.mag = 9'(e % 512);
    m.val = 10'(x % 1024);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
  endtask

  // One complete pass; mode 0 ready always high, 1 random ready, 2 ready low for 10 cycles on the first element.
  task automatic do_pass(input int sel, input int cnt, input int mode);
    int      n;
    int      k;
    int      c;
    int      first;
    int      hold;
    bit      done_seen;
    bit      r;
    fields_t e;
    n         = (cnt > 32) ? 32 : cnt;
    k         = 0;
    c         = 0;
    first     = -1;
    hold      = 10;
    done_seen = 1'b0;
    element_count = 6'(cnt);
    start[sel] = 1'b1;
    tick();
    start[sel] = 1'b0;
    element_count = 6'($urandom_range(0, 63));
    while (c < 3000 && !done_seen) begin
      if (done[sel]) begin
        done_seen = 1'b1;
        checks++;
        if (k != n) begin errors++; $display("FAIL count sel=%0d got=%0d exp=%0d", sel, k, n); end
        checks++;
        if (busy[sel] !== 1'b0) begin errors++; $display("FAIL busy_at_done sel=%0d got=%0b exp=0", sel, busy[sel]); end
        if (n == 0) begin
          checks++;
          if (c != 1) begin errors++; $display("FAIL zero_done_cycle sel=%0d got=%0d exp=1", sel, c); end
        end
      end else begin
        checks++;
        if (busy[sel] !== 1'b1) begin errors++; $display("FAIL busy sel=%0d cyc=%0d got=%0b exp=1", sel, c, busy[sel]); end
      end
      if (ev[sel] === 1'b1) begin
        if (first < 0) begin
          first = c;
          checks++;
          if (c != sel + 3) begin errors++; $display("FAIL latency sel=%0d got=%0d exp=%0d", sel, c, sel + 3); end
        end
        checks++;
        if (k >= n) begin
          errors++;
          $display("FAIL extra_valid sel=%0d got=idx%0d exp=none", sel, ei[sel]);
        end else begin
          e = model(mem[k]);
          if ({ei[sel], na[sel], nb[sel], et[sel], eneg[sel], emag[sel], eval[sel], einv[sel]} !==
              {5'(k), e.a, e.b, e.t, e.neg, e.mag, e.val, (e.t == 2'd3)}) begin
            errors++;
            $display("FAIL fields sel=%0d k=%0d got=%h exp=%h", sel, k,
                     {ei[sel], na[sel], nb[sel], et[sel], eneg[sel], emag[sel], eval[sel], einv[sel]},
                     {5'(k), e.a, e.b, e.t, e.neg, e.mag, e.val, (e.t == 2'd3)});
          end
        end
        if (mode == 0) r = 1'b1;
        else if (mode == 1) r = 1'($urandom_range(0, 1));
        else if (hold > 0) begin r = 1'b0; hold--; end
        else r = 1'b1;
        elem_ready = r;
        if (r) k++;
      end else begin
        elem_ready = 1'($urandom_range(0, 1));
      end
      if (!done[sel] && busy[sel] && ($urandom_range(0, 7) == 0)) start[sel] = 1'b1;
      tick();
      start[sel] = 1'b0;
      c++;
    end
    checks++;
    if (!done_seen) begin errors++; $display("FAIL timeout sel=%0d got=no_done exp=done", sel); end
    checks++;
    if ({done[sel], busy[sel], ev[sel]} !== 3'b000) begin
      errors++;
      $display("FAIL after_done sel=%0d got=%b exp=000", sel, {done[sel], busy[sel], ev[sel]});
    end
  endtask

  task automatic check_all_zero(input int sel, input string tag);
    checks++;
    if ({ea[sel], ev[sel], ei[sel], et[sel], eval[sel], eneg[sel], emag[sel], na[sel], nb[sel],
         einv[sel], busy[sel], done[sel]} !== 46'd0) begin
      errors++;
      $display("FAIL %s sel=%0d got=%h exp=0", tag, sel,
               {ea[sel], ev[sel], ei[sel], et[sel], eval[sel], eneg[sel], emag[sel], na[sel], nb[sel],
                einv[sel], busy[sel], done[sel]});
    end
  endtask

  task automatic test_reset();
    check_all_zero(0, "reset_state");
    check_all_zero(1, "reset_state");
  endtask

  task automatic test_basic(input int sel);
    fill_random();
    do_pass(sel, 3, 0);
  endtask

  // Bit 18 is set in this word, so by the field layout exp_mag is 0x103.
  task automatic test_known_word(input int sel);
    mem[0] = 32'h0884_0C05;
    do_pass(sel, 1, 0);
    checks++;
    if ({na[sel], nb[sel], et[sel], eneg[sel], emag[sel], eval[sel]} !==
        {5'd1, 5'd2, 2'd0, 1'b0, 9'h103, 10'd5}) begin
      errors++;
      $display("FAIL known_word sel=%0d got=%h exp=%h", sel,
               {na[sel], nb[sel], et[sel], eneg[sel], emag[sel], eval[sel]},
               {5'd1, 5'd2, 2'd0, 1'b0, 9'h103, 10'd5});
    end
  endtask

  task automatic test_neg_invalid(input int sel);
    mem[0] = {5'd4, 5'd6, 2'd3, 10'h203, 10'd700};
    do_pass(sel, 1, 0);
    checks++;
    if ({eneg[sel], emag[sel], et[sel], einv[sel]} !== {1'b1, 9'd3, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL neg_invalid_hold sel=%0d got=%h exp=%h", sel,
               {eneg[sel], emag[sel], et[sel], einv[sel]}, {1'b1, 9'd3, 2'd3, 1'b0});
    end
  endtask

  task automatic test_backpressure(input int sel);
    fill_random();
    do_pass(sel, 4, 2);
  endtask

  task automatic test_count_bounds(input int sel);
    fill_random();
    do_pass(sel, 0, 0);
    do_pass(sel, 40, 1);
    checks++;
    if (ei[sel] !== 5'd31) begin errors++; $display("FAIL last_idx sel=%0d got=%0d exp=31", sel, ei[sel]); end
  endtask

  task automatic test_random(input int sel);
    for (int p = 0; p < 4; p++) begin
      fill_random();
      do_pass(sel, $urandom_range(1, 12), 1);
    end
  endtask

  task automatic test_reset_mid_pass(input int sel);
    int  c;
    bit  bad;
    fill_random();
    element_count = 6'd5;
    elem_ready    = 1'b1;
    start[sel]    = 1'b1;
    tick();
    start[sel] = 1'b0;
    c = 0;
    while (c < 200 && !(ev[sel] === 1'b1 && ei[sel] === 5'd2)) begin
      tick();
      c++;
    end
    checks++;
    if (c >= 200) begin errors++; $display("FAIL reach_idx2 sel=%0d got=timeout exp=idx2", sel); end
    reset = 1'b1;
    #1;
    check_all_zero(sel, "reset_async");
    tick();
    check_all_zero(sel, "reset_held");
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done[sel] !== 1'b0 || busy[sel] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL no_done_after_abort sel=%0d got=activity exp=idle", sel); end
    do_pass(sel, 4, 0);
  endtask

  initial begin
    reset         = 1'b1;
    start[0]      = 1'b0;
    start[1]      = 1'b0;
    elem_ready    = 1'b0;
    element_count = 6'd0;
    fill_random();
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    for (int s = 0; s < 2; s++) begin
      test_basic(s);
      test_known_word(s);
      test_neg_invalid(s);
      test_backpressure(s);
      test_count_bounds(s);
      test_random(s);
      test_reset_mid_pass(s);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
